// File: rtl/puf_cipher_scheduler.sv
// Sequencer for a PUF/cipher core: applies a challenge, lets the core settle, captures
// its outputs and streams them out as three bytes over a valid/ready handshake.
module puf_cipher_scheduler #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  challenge_in,
  output logic [3:0]  core_challenge,
  input  logic [15:0] core_encoded_char,
  input  logic [7:0]  core_puf_response,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        err_overrun
);

  // state  | meaning
  // IDLE   | waiting for start
  // SETTLE | challenge applied, counting down core settle time
  // SEND0  | presenting encoded_char[7:0]
  // SEND1  | presenting encoded_char[15:8]
  // SEND2  | presenting puf_response; a start on its transfer edge chains
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SEND0  = 3'd2,
    SEND1  = 3'd3,
    SEND2  = 3'd4
  } state_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  chal_q, chal_d;
  logic [15:0] enc_q, enc_d;
  logic [7:0]  puf_q, puf_d;
  logic        err_q, err_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'h00;
      chal_q  <= 4'h0;
      enc_q   <= 16'h0000;
      puf_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chal_q  <= chal_d;
      enc_q   <= enc_d;
      puf_q   <= puf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    chal_d    = chal_q;
    enc_d     = enc_q;
    puf_d     = puf_q;
    err_d     = err_q;
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (start) begin
          chal_d  = challenge_in;
          cnt_d   = SETTLE_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (start) err_d = 1'b1;
        if (cnt_q == 8'h00) begin
          enc_d   = core_encoded_char;
          puf_d   = core_puf_response;
          state_d = SEND0;
        end else begin
          cnt_d = cnt_q - 8'h01;
        end
      end
      SEND0: begin
        out_valid = 1'b1;
        out_data  = enc_q[7:0];
        if (start) err_d = 1'b1;
        if (out_ready) state_d = SEND1;
      end
      SEND1: begin
        out_valid = 1'b1;
        out_data  = enc_q[15:8];
        if (start) err_d = 1'b1;
        if (out_ready) state_d = SEND2;
      end
      SEND2: begin
        out_valid = 1'b1;
        out_data  = puf_q;
        if (out_ready) begin
          // Start coinciding with the last transfer chains straight into the next challenge.
          if (start) begin
            chal_d  = challenge_in;
            cnt_d   = SETTLE_INIT;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign core_challenge = chal_q;
  assign busy           = (state_q != IDLE);
  assign err_overrun    = err_q;

endmodule
